// File: rtl/bpi_cmd_pkg.sv
// BPI/CFI command set shared by the flash controller and the loopback responder:
// command bytes, status-register bit positions, ID codes and responder modes.
package bpi_cmd_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 26;

  localparam logic [7:0] CMD_RD_ARRAY   = 8'hFF;
  localparam logic [7:0] CMD_RD_STATUS  = 8'h70;
  localparam logic [7:0] CMD_CLR_STATUS = 8'h50;
  localparam logic [7:0] CMD_RD_ID      = 8'h90;
  localparam logic [7:0] CMD_PROG       = 8'h40;
  localparam logic [7:0] CMD_PROG_ALT   = 8'h10;
  localparam logic [7:0] CMD_ERASE      = 8'h20;
  localparam logic [7:0] CMD_CONFIRM    = 8'hD0;

  localparam int unsigned SR_READY     = 7;
  localparam int unsigned SR_ERASE_ERR = 5;
  localparam int unsigned SR_PROG_ERR  = 4;

  localparam logic [DATA_W-1:0] ID_MFR = 16'h0089;
  localparam logic [DATA_W-1:0] ID_DEV = 16'h8960;

  typedef enum logic [2:0] {
    MODE_RD_ARRAY,
    MODE_RD_STATUS,
    MODE_RD_ID,
    MODE_PROG_SETUP,
    MODE_ERASE_SETUP,
    MODE_BUSY_PROG,
    MODE_BUSY_ERASE
  } mode_t;

  function automatic logic [DATA_W-1:0] status_word(input logic ready,
                                                    input logic erase_err,
                                                    input logic prog_err);
    logic [DATA_W-1:0] sr;
    sr               = '0;
    sr[SR_READY]     = ready;
    sr[SR_ERASE_ERR] = erase_err;
    sr[SR_PROG_ERR]  = prog_err;
    return sr;
  endfunction

endpackage

// File: rtl/bpi_resp_ram.sv
// Single-port word RAM backing the emulated flash array; synchronous read,
// contents start erased (all ones) at configuration and survive reset.
module bpi_resp_ram #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW] = '{default: {DW{1'b1}}};

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/bpi_flash_responder.sv
// Far-end responder for the BPI NOR flash bus: decodes the CFI command subset,
// emulates program/erase busy times and answers array, status and ID reads.
module bpi_flash_responder
  import bpi_cmd_pkg::*;
#(
  parameter int unsigned MEM_AW       = 12,
  parameter int unsigned BLK_AW       = 6,
  parameter int unsigned PROG_CYCLES  = 16,
  parameter int unsigned ERASE_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flash_rst_n,
  input  logic              flash_ce_n,
  input  logic              flash_we_n,
  input  logic              flash_oe_n,
  input  logic [ADDR_W-1:0] flash_addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  output logic              busy,
  output logic              bus_conflict
);

  localparam int unsigned MAX_CYC = (ERASE_CYCLES > PROG_CYCLES) ? ERASE_CYCLES : PROG_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  logic              reset;
  logic              we_q;
  logic              we_edge;
  logic [MEM_AW-1:0] addr_q;
  logic [DATA_W-1:0] din_q;

  mode_t             state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_e_q, err_e_d;
  logic              err_p_q, err_p_d;
  logic [MEM_AW-1:0] tgt_addr_q, tgt_addr_d;
  logic [DATA_W-1:0] tgt_data_q, tgt_data_d;

  logic              ram_we;
  logic [MEM_AW-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic              ready;
  logic              rd_is_array;
  logic [DATA_W-1:0] rd_word;
  logic              unused_addr_hi;

  assign reset          = rst || !flash_rst_n;
  assign we_edge        = !we_q && flash_we_n && !flash_ce_n;
  assign ready          = !((state_q == MODE_BUSY_PROG) || (state_q == MODE_BUSY_ERASE));
  assign unused_addr_hi = ^flash_addr[ADDR_W-1:MEM_AW];

  // Array reads come straight from the RAM's output register; other reads from rd_word.
  assign data_out = rd_is_array ? ram_rdata : rd_word;

  bpi_resp_ram #(.AW(MEM_AW), .DW(DATA_W)) u_ram (
    .clk   (clk),
    .we    (ram_we && !reset),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Command decode, busy sequencing and RAM port arbitration.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_e_d    = err_e_q;
    err_p_d    = err_p_q;
    tgt_addr_d = tgt_addr_q;
    tgt_data_d = tgt_data_q;
    ram_we     = 1'b0;
    ram_addr   = flash_addr[MEM_AW-1:0];
    ram_wdata  = '1;
    case (state_q)
      MODE_RD_ARRAY, MODE_RD_STATUS, MODE_RD_ID: begin
        if (we_edge) begin
          case (din_q[7:0])
            CMD_RD_ARRAY:           state_d = MODE_RD_ARRAY;
            CMD_RD_STATUS:          state_d = MODE_RD_STATUS;
            CMD_RD_ID:              state_d = MODE_RD_ID;
            CMD_PROG, CMD_PROG_ALT: state_d = MODE_PROG_SETUP;
            CMD_ERASE:              state_d = MODE_ERASE_SETUP;
            CMD_CLR_STATUS: begin
              err_e_d = 1'b0;
              err_p_d = 1'b0;
            end
            default: ;
          endcase
        end
      end
      MODE_PROG_SETUP: begin
        // Pre-read the target word so the old contents are ready for the AND merge.
        ram_addr = addr_q;
        if (we_edge) begin
          state_d    = MODE_BUSY_PROG;
          tgt_addr_d = addr_q;
          tgt_data_d = din_q;
          cnt_d      = '0;
        end
      end
      MODE_ERASE_SETUP: begin
        if (we_edge) begin
          if (din_q[7:0] == CMD_CONFIRM) begin
            state_d    = MODE_BUSY_ERASE;
            tgt_addr_d = {addr_q[MEM_AW-1:BLK_AW], BLK_AW'(0)};
            cnt_d      = '0;
          end else begin
            err_e_d = 1'b1;
            err_p_d = 1'b1;
            state_d = MODE_RD_STATUS;
          end
        end
      end
      MODE_BUSY_PROG: begin
        ram_addr = tgt_addr_q;
        if (cnt_q == CNT_W'(PROG_CYCLES - 1)) begin
          ram_we    = 1'b1;
          ram_wdata = ram_rdata & tgt_data_q;
          state_d   = MODE_RD_STATUS;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      MODE_BUSY_ERASE: begin
        ram_addr = {tgt_addr_q[MEM_AW-1:BLK_AW], cnt_q[BLK_AW-1:0]};
        ram_we   = cnt_q < CNT_W'(2**BLK_AW);
        if (cnt_q == CNT_W'(ERASE_CYCLES - 1)) begin
          state_d = MODE_RD_STATUS;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = MODE_RD_ARRAY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= MODE_RD_ARRAY;
      cnt_q      <= '0;
      err_e_q    <= 1'b0;
      err_p_q    <= 1'b0;
      tgt_addr_q <= '0;
      tgt_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_e_q    <= err_e_d;
      err_p_q    <= err_p_d;
      tgt_addr_q <= tgt_addr_d;
      tgt_data_q <= tgt_data_d;
    end
  end

  // Bus-side pipeline: strobe history, read response and conflict flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q         <= 1'b1;
      addr_q       <= '0;
      din_q        <= '0;
      data_oe      <= 1'b0;
      rd_is_array  <= 1'b0;
      rd_word      <= '0;
      busy         <= 1'b0;
      bus_conflict <= 1'b0;
    end else begin
      we_q        <= flash_we_n;
      addr_q      <= flash_addr[MEM_AW-1:0];
      din_q       <= data_in;
      data_oe     <= !flash_ce_n && !flash_oe_n && flash_we_n;
      rd_is_array <= (state_q == MODE_RD_ARRAY);
      rd_word     <= (state_q == MODE_RD_ID) ? (flash_addr[0] ? ID_DEV : ID_MFR)
                                             : status_word(ready, err_e_q, err_p_q);
      busy        <= (state_d == MODE_BUSY_PROG) || (state_d == MODE_BUSY_ERASE);
      if (data_oe && data_in_en) bus_conflict <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bpi_flash_responder.sv
// Randomized scoreboard bench for bpi_flash_responder against a behavioural
// flash model (array, modes, status bits and busy windows in cycle numbers).
module tb_bpi_flash_responder;

  localparam int P = 16;
  localparam int E = 256;
  localparam int M_ARRAY = 0, M_STATUS = 1, M_ID = 2, M_PSETUP = 3, M_ESETUP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flash_rst_n = 1'b1;
  logic        ce = 1'b1, we = 1'b1, oe = 1'b1;
  logic [25:0] addr = '0;
  logic [15:0] din = '0;
  logic        din_en = 1'b0;
  logic [15:0] dout;
  logic        doe, busy, conflict;

  int checks = 0;
  int errors = 0;

  bpi_flash_responder #(.MEM_AW(12), .BLK_AW(6), .PROG_CYCLES(P), .ERASE_CYCLES(E)) dut (
    .clk          (clk),
    .rst          (rst),
    .flash_rst_n  (flash_rst_n),
    .flash_ce_n   (ce),
    .flash_we_n   (we),
    .flash_oe_n   (oe),
    .flash_addr   (addr),
    .data_in      (din),
    .data_in_en   (din_en),
    .data_out     (dout),
    .data_oe      (doe),
    .busy         (busy),
    .bus_conflict (conflict)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [15:0] mem_m [4096];
  int          mode_m = M_ARRAY;
  bit          err5_m = 0, err4_m = 0;
  int          pend = 0;  // 0 none, 1 program, 2 erase
  int          pend_a = 0;
  logic [15:0] pend_d = '0;
  longint      busy_from = -1, busy_until = -1;
  longint      now = 0;
  logic [15:0] sb [$];

  function automatic void chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%h expected=0x%h time=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic void settle(longint t);
    if (pend != 0 && t > busy_until) begin
      if (pend == 1) mem_m[pend_a] = mem_m[pend_a] & pend_d;
      else for (int k = 0; k < 64; k++) mem_m[pend_a + k] = 16'hFFFF;
      pend = 0;
    end
  endfunction

  function automatic bit model_busy(longint t);
    return (pend != 0) && (t > busy_from) && (t <= busy_until);
  endfunction

  function automatic logic [15:0] model_sr(bit rdy);
    return (rdy ? 16'h0080 : 16'h0000) | (err5_m ? 16'h0020 : 16'h0000) |
           (err4_m ? 16'h0010 : 16'h0000);
  endfunction

  function automatic logic [15:0] model_read(logic [25:0] a, longint t);
    settle(t);
    if (pend != 0) return model_sr(0);
    if (mode_m == M_ID) return a[0] ? 16'h8960 : 16'h0089;
    if (mode_m == M_ARRAY) return mem_m[int'(a) % 4096];
    return model_sr(1);
  endfunction

  function automatic void model_write(logic [25:0] a, logic [15:0] d, longint t);
    settle(t);
    if (pend != 0) return;
    if (mode_m == M_PSETUP) begin
      pend = 1; pend_a = int'(a) % 4096; pend_d = d;
      busy_from = t; busy_until = t + P; mode_m = M_STATUS;
    end else if (mode_m == M_ESETUP) begin
      mode_m = M_STATUS;
      if (d[7:0] == 8'hD0) begin
        pend = 2; pend_a = ((int'(a) % 4096) / 64) * 64;
        busy_from = t; busy_until = t + E;
      end else begin
        err5_m = 1; err4_m = 1;
      end
    end else begin
      case (d[7:0])
        8'hFF: mode_m = M_ARRAY;
        8'h70: mode_m = M_STATUS;
        8'h90: mode_m = M_ID;
        8'h40, 8'h10: mode_m = M_PSETUP;
        8'h20: mode_m = M_ESETUP;
        8'h50: begin err5_m = 0; err4_m = 0; end
        default: ;
      endcase
    end
  endfunction

  function automatic void model_reset(longint r);
    settle(r);
    if (pend == 2)
      for (int k = 0; k < 64; k++) if (busy_from + 1 + k < r) mem_m[pend_a + k] = 16'hFFFF;
    pend = 0; mode_m = M_ARRAY; err5_m = 0; err4_m = 0;
    busy_from = -1; busy_until = -1;
  endfunction

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    #1;
    if (doe === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_read", dout, 16'hxxxx);
      else chk("read_data", dout, sb.pop_front());
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(negedge clk);
    now++;
    chk("busy", 16'(busy), 16'(model_busy(now)));
  endtask

  task automatic drive_idle();
    ce = 1'b1; we = 1'b1; oe = 1'b1; din_en = 1'b0;
  endtask

  task automatic idle1();
    step(); drive_idle();
  endtask

  task automatic rd(input logic [25:0] a);
    step();
    ce = 1'b0; oe = 1'b0; we = 1'b1; din_en = 1'b0; addr = a;
    sb.push_back(model_read(a, now));
  endtask

  task automatic wr(input logic [25:0] a, input logic [15:0] d);
    step();
    ce = 1'b0; we = 1'b0; oe = 1'b1; din_en = 1'b1; addr = a; din = d;
    step();
    we = 1'b1;
    model_write(a, d, now);
    idle1();
  endtask

  task automatic wait_done();
    while (now <= busy_until) idle1();
  endtask

  task automatic prog(input logic [25:0] a, input logic [15:0] d);
    wr(a, 16'h0040); wr(a, d); wait_done();
  endtask

  task automatic reset_pulse(input bit use_pin);
    step(); drive_idle();
    if (use_pin) flash_rst_n = 1'b0; else rst = 1'b1;
    model_reset(now);
    step(); rst = 1'b0; flash_rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [25:0] ra;
    logic [15:0] rdv;
    for (int i = 0; i < 4096; i++) mem_m[i] = 16'hFFFF;
    step(); step();
    reset_pulse(0);
    chk("rst_data_oe", 16'(doe), 16'h0000);
    chk("rst_data_out", dout, 16'h0000);
    chk("rst_conflict", 16'(conflict), 16'h0000);

    // read after reset, one-cycle latency
    idle1();
    chk("oe_idle", 16'(doe), 16'h0000);
    rd(26'h000005);
    idle1();
    chk("oe_latency", 16'(doe), 16'h0001);
    chk("latency_data", dout, 16'hFFFF);
    idle1();

    // program, poll status across the busy window, read back, reprogram
    wr(26'h10, 16'h0040);
    wr(26'h10, 16'h1234);
    repeat (P + 3) rd(26'h0);
    idle1();
    wr(26'h0, 16'h00FF);
    rd(26'h10); idle1();
    wr(26'h10, 16'h0010);
    wr(26'h10, 16'hFF0F);
    wr(26'h10, 16'h00FF);  // lands during busy: ignored
    wait_done();
    rd(26'h10); idle1();
    wr(26'h0, 16'h00FF);
    rd(26'h10); idle1();

    // block erase of 0x40..0x7F, neighbours untouched
    prog(26'h3F, 16'hA5A5);
    prog(26'h40, 16'h00FF);
    prog(26'h7F, 16'h0F0F);
    prog(26'h80, 16'h1111);
    wr(26'h45, 16'h0020);
    wr(26'h45, 16'h00D0);
    while (now < busy_until - 2) idle1();
    repeat (5) rd(26'h0);
    idle1();
    wr(26'h0, 16'h00FF);
    rd(26'h3F); rd(26'h40); rd(26'h55); rd(26'h7F); rd(26'h80); idle1();

    // erase sequence error and clear
    wr(26'h0, 16'h0020);
    wr(26'h0, 16'h0055);
    rd(26'h0); idle1();
    wr(26'h0, 16'h0050);
    rd(26'h0); idle1();

    // read ID
    wr(26'h0, 16'h0090);
    rd(26'h0); rd(26'h1); rd(26'h3FFFFFF); rd(26'h2000000); idle1();

    // reset part-way through an erase of block 0x80..0xBF
    prog(26'h80, 16'h1357);
    prog(26'h92, 16'h1357);
    prog(26'h93, 16'h1357);
    prog(26'hA8, 16'h1357);
    wr(26'h80, 16'h0020);
    wr(26'h80, 16'h00D0);
    while (now < busy_from + 19) idle1();
    reset_pulse(1);
    chk("abort_busy", 16'(busy), 16'h0000);
    chk("abort_oe", 16'(doe), 16'h0000);
    rd(26'h80); rd(26'h92); rd(26'h93); rd(26'hA8); idle1();
    wr(26'h0, 16'h0070);
    rd(26'h0); idle1();

    // randomized traffic
    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(0, 4))
        0: begin
          ra = 26'($urandom());
          rdv = 16'($urandom());
          wr(ra, ($urandom_range(0, 1) == 1) ? 16'h0040 : 16'h0010);
          wr(ra, rdv);
          wait_done();
          wr(26'($urandom()), {8'($urandom()), 8'hFF});
          rd(ra); idle1();
        end
        1: begin
          wr(26'($urandom()), 16'h00FF);
          repeat (4) rd(26'($urandom()));
          idle1();
        end
        2: begin
          wr(26'($urandom()), {8'($urandom()), 8'h70});
          rd(26'($urandom())); rd(26'($urandom())); idle1();
        end
        3: begin
          wr(26'($urandom()), 16'h0090);
          repeat (3) rd(26'($urandom()));
          idle1();
        end
        default: begin
          ra = 26'($urandom());
          wr(ra, 16'h0020);
          wr(ra, 16'h00D0);
          wait_done();
          wr(26'h0, 16'h00FF);
          rd(ra); rd({ra[25:6], 6'h00}); rd({ra[25:6], 6'h3F}); idle1();
        end
      endcase
    end

    // bus conflict: controller drives while responder drives, sticky until reset
    chk("conflict_clear", 16'(conflict), 16'h0000);
    wr(26'h0, 16'h00FF);
    rd(26'h20);
    step();
    ce = 1'b0; oe = 1'b0; we = 1'b1; addr = 26'h21; din_en = 1'b1;
    sb.push_back(model_read(26'h21, now));
    idle1();
    chk("conflict_set", 16'(conflict), 16'h0001);
    repeat (6) idle1();
    chk("conflict_sticky", 16'(conflict), 16'h0001);
    reset_pulse(0);
    chk("conflict_rst", 16'(conflict), 16'h0000);

    repeat (3) idle1();
    chk("scoreboard_drained", 16'(sb.size()), 16'h0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
